demux32_1to2_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 25 ++
 rtl/fifo2.sv | 98 +++++++++
 rtl/demux32_1to2_stream.sv | 90 +++++++++
 tb/tb_demux32_1to2_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and defaults for the 1-to-2 stream demultiplexer.
//               Holds the default widths, the per-port buffer depth, the word
//               type and the buffer occupancy encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 16;
    localparam int BUF_DEPTH     = 2;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

    // Occupancy of a per-port buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage
`default_nettype wire

// File: rtl/fifo2.sv
`default_nettype none
// ============================================================================
// Module      : fifo2
// Description : Two-entry register FIFO. The head word always lives in
//               r_mem0, so the head output is a plain register with no read
//               mux. A push into a full FIFO and a pop from an empty FIFO are
//               ignored.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push, din      - write request and word
//               pop            - remove the head word
//               full, empty    - occupancy flags
//               head           - oldest stored word (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    occ_t             r_occ;
    occ_t             w_occ_nxt;
    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_occ != OCC_FULL);
    assign w_pop  = pop  && (r_occ != OCC_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_push) begin
                    w_occ_nxt = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (w_push && !w_pop) begin
                    w_occ_nxt = OCC_FULL;
                end else if (w_pop && !w_push) begin
                    w_occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_occ_nxt = OCC_ONE;
                end
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    // Storage: pops shift the second entry forward; a push lands in the
    // first free slot. Push+pop in ONE replaces the head directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else if (w_pop) begin
            if (r_occ == OCC_FULL) begin
                r_mem0 <= r_mem1;
            end else if (w_push) begin
                r_mem0 <= din;
            end
        end else if (w_push) begin
            if (r_occ == OCC_EMPTY) begin
                r_mem0 <= din;
            end else begin
                r_mem1 <= din;
            end
        end
    end

    assign full  = (r_occ == OCC_FULL);
    assign empty = (r_occ == OCC_EMPTY);
    assign head  = r_mem0;

endmodule
`default_nettype wire

// File: rtl/demux32_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux32_1to2_stream
// Description : Registered 1-to-2 stream demultiplexer. Each word accepted on
//               the input is routed by in_sel into one of two independent
//               2-entry FIFOs, so a stalled port never blocks the other.
//               Saturating per-port counters record delivered words.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid/in_ready/in_data  - input stream
//               in_sel                     - destination port (0 or 1)
//               outN_valid/ready/data      - output streams, N = 0, 1
//               cnt0, cnt1                 - words delivered per port
// Revision    : 1.0 - initial release
// ============================================================================
module demux32_1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic [1:0] w_out_ready;

    assign w_out_ready = {out1_ready, out0_ready};

    // Ready depends only on the addressed buffer, never on downstream ready.
    assign in_ready = !w_full[in_sel];

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [WIDTH-1:0] w_head;
            logic [CNT_W-1:0] r_cnt;

            assign w_push[p] = in_valid && in_ready && (in_sel == 1'(p));
            assign w_pop[p]  = !w_empty[p] && w_out_ready[p];

            fifo2 #(
                .WIDTH (WIDTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (w_push[p]),
                .pop   (w_pop[p]),
                .din   (in_data),
                .full  (w_full[p]),
                .empty (w_empty[p]),
                .head  (w_head)
            );

            // Saturates at all-ones so a long run never wraps to zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_pop[p] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    endgenerate

    assign out0_valid = !w_empty[0];
    assign out1_valid = !w_empty[1];
    assign out0_data  = g_port[0].w_head;
    assign out1_data  = g_port[1].w_head;
    assign cnt0       = g_port[0].r_cnt;
    assign cnt1       = g_port[1].r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux32_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux32_1to2_stream
// Description : Self-checking bench for demux32_1to2_stream. A queue-based
//               reference model tracks each port's contents and delivered
//               count; outputs are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux32_1to2_stream;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 1'b0;
    logic             out0_valid, out1_valid;
    logic             out0_ready = 1'b0, out1_ready = 1'b0;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [CNT_W-1:0] cnt0, cnt1;

    demux32_1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        chk("in_ready", 32'(in_ready), 32'(((in_sel ? q1.size() : q0.size()) < 2)));
        chk("cnt0", 32'(cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    endtask

    // One clock: check at the falling edge, then apply the handshake rules
    // to the model at the rising edge. Returns 1 time unit after the edge.
    task automatic cycle();
        bit pop0, pop1, push0, push1, room;
        @(negedge clk);
        check_model();
        pop0  = (q0.size() != 0) && out0_ready;
        pop1  = (q1.size() != 0) && out1_ready;
        room  = (in_sel ? q1.size() : q0.size()) < 2;
        push0 = in_valid && room && !in_sel;
        push1 = in_valid && room && in_sel;
        @(posedge clk);
        if (pop0) begin void'(q0.pop_front()); if (m_cnt0 < 65535) m_cnt0++; end
        if (pop1) begin void'(q1.pop_front()); if (m_cnt1 < 65535) m_cnt1++; end
        if (push0) q0.push_back(in_data);
        if (push1) q1.push_back(in_data);
        #1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data", out0_data, 32'd0);
        chk("rst_out1_data", out1_data, 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;

        // Basic route
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0043);
        cycle();
        chk("route_out0_valid", 32'(out0_valid), 32'd1);
        chk("route_out0_data", out0_data, 32'h0000_0043);
        drive(1'b1, 1'b1, 32'h8000_007F);
        cycle();
        chk("route_out1_valid", 32'(out1_valid), 32'd1);
        chk("route_out1_data", out1_data, 32'h8000_007F);
        drive(1'b0, 1'b0, 32'h0);
        cycle();
        cycle();
        chk("route_cnt0", 32'(cnt0), 32'd1);
        chk("route_cnt1", 32'(cnt1), 32'd1);

        // Backpressure and fill on port 0
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h1);
        cycle();
        drive(1'b1, 1'b0, 32'h2);
        cycle();
        drive(1'b1, 1'b0, 32'h3);
        #1 chk("bp_ready_sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1 chk("bp_ready_sel1", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        cycle();
        out0_ready = 1'b1;
        chk("drain_first", out0_data, 32'h1);
        cycle();
        chk("drain_second", out0_data, 32'h2);
        cycle();
        chk("drain_empty", 32'(out0_valid), 32'd0);

        // Simultaneous push/pop while port 0 holds one word
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hA);
        cycle();
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hB);
        cycle();
        chk("pp_valid", 32'(out0_valid), 32'd1);
        chk("pp_head", out0_data, 32'hB);
        drive(1'b0, 1'b0, 32'h0);
        cycle();
        chk("pp_empty", 32'(out0_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        drive(1'b0, 1'b0, 32'h0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        // Counter saturation on port 1
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 1'b1, 32'(i));
            cycle();
        end
        drive(1'b0, 1'b0, 32'h0);
        cycle();
        cycle();
        chk("sat_cnt1", 32'(cnt1), 32'h0000_FFFF);

        // Fill both ports then reset asynchronously mid-cycle
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h11); cycle();
        drive(1'b1, 1'b0, 32'h12); cycle();
        drive(1'b1, 1'b1, 32'h21); cycle();
        drive(1'b1, 1'b1, 32'h22); cycle();
        drive(1'b0, 1'b0, 32'h0);
        #1 chk("full_ready0", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out0_valid", 32'(out0_valid), 32'd0);
        chk("arst_out1_valid", 32'(out1_valid), 32'd0);
        chk("arst_out0_data", out0_data, 32'd0);
        chk("arst_out1_data", out1_data, 32'd0);
        chk("arst_cnt0", 32'(cnt0), 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("arst_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b1, 32'hCAFE_F00D);
        cycle();
        chk("post_rst_valid", 32'(out1_valid), 32'd1);
        chk("post_rst_data", out1_data, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, 32'h0);
        out1_ready = 1'b1;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
